// File: rtl/user_str_rr_arbiter.sv
// Four-way round-robin merge of 64-bit user streams into one tagged stream.
// Bursts of up to MAX_BURST beats per grant, one-entry output register, per-stream beat counters.
module user_str_rr_arbiter #(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 32
) (
    input  logic                  i_user_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_str_data_valid,
    output logic [3:0]            o_str_ack,
    input  logic [4*DATA_W-1:0]   i_str_data,
    output logic                  o_data_valid,
    input  logic                  i_ack,
    output logic [DATA_W-1:0]     o_data,
    output logic [1:0]            o_str_id,
    output logic                  o_last,
    output logic [4*CNT_W-1:0]    o_beat_cnt,
    output logic                  o_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int              BCNT_W   = 9;
    localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(MAX_BURST - 1);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          id_q, id_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q [4];
    logic [CNT_W-1:0]    cnt_d [4];

    logic                load_ok_s;
    logic                accept_s;

    // First requester strictly after ptr in cyclic order ptr+1 .. ptr+4.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Handshake terms; ack never looks at the input valids.
    always_comb begin
        load_ok_s = ~vld_q | i_ack;
        accept_s  = (state_q == ST_BURST) & load_ok_s & i_str_data_valid[grant_q];
        o_str_ack = 4'b0000;
        if ((state_q == ST_BURST) && load_ok_s) begin
            o_str_ack[grant_q] = 1'b1;
        end else begin
            o_str_ack = 4'b0000;
        end
    end

    // Next-state: output register, arbitration FSM and beat counters.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        vld_d   = vld_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n];
        end

        if (accept_s) begin
            vld_d  = 1'b1;
            data_d = i_str_data[int'(grant_q)*DATA_W +: DATA_W];
            id_d   = grant_q;
            last_d = (bcnt_q == LAST_CNT);
            cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
        end else if (vld_q && i_ack) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (|i_str_data_valid) begin
                    grant_d = rr_pick(ptr_q, i_str_data_valid);
                    bcnt_d  = {BCNT_W{1'b0}};
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (load_ok_s) begin
                    if (i_str_data_valid[grant_q]) begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                        if (bcnt_q == LAST_CNT) begin
                            ptr_d   = grant_q;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BURST;
                        end
                    end else begin
                        // Source went quiet: release; tag a still-held beat as the burst end.
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                        if (vld_q && !i_ack) begin
                            last_d = 1'b1;
                        end else begin
                            last_d = last_d;
                        end
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd3;
            bcnt_q  <= {BCNT_W{1'b0}};
            vld_q   <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            id_q    <= 2'd0;
            last_q  <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Output mapping from registered state.
    always_comb begin
        o_data_valid = vld_q;
        o_data       = data_q;
        o_str_id     = id_q;
        o_last       = last_q;
        o_busy       = (state_q == ST_BURST) | vld_q;
        o_beat_cnt   = {(4*CNT_W){1'b0}};
        for (int n = 0; n < 4; n++) begin
            o_beat_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
        end
    end

endmodule

// File: tb/tb_user_str_rr_arbiter.sv
// Directed bench for user_str_rr_arbiter: stream sources, output scoreboard and
// hand-derived checks on grant order, burst ends, gaps and counters.
module tb_user_str_rr_arbiter;
    localparam int DW  = 64;
    localparam int CW  = 32;
    localparam int CW2 = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       vld;
    logic [4*DW-1:0]  sdata;
    logic             ack_in;

    logic [3:0]       o_str_ack;
    logic             o_data_valid;
    logic [DW-1:0]    o_data;
    logic [1:0]       o_str_id;
    logic             o_last;
    logic [4*CW-1:0]  o_beat_cnt;
    logic             o_busy;

    logic [3:0]       o2_str_ack;
    logic             o2_data_valid;
    logic [DW-1:0]    o2_data;
    logic [1:0]       o2_str_id;
    logic             o2_last;
    logic [4*CW2-1:0] o2_beat_cnt;
    logic             o2_busy;

    always #5 clk = ~clk;

    user_str_rr_arbiter #(.DATA_W(DW), .MAX_BURST(16), .CNT_W(CW)) dut (
        .i_user_clk(clk), .i_rst(rst_n), .i_str_data_valid(vld), .o_str_ack(o_str_ack),
        .i_str_data(sdata), .o_data_valid(o_data_valid), .i_ack(ack_in), .o_data(o_data),
        .o_str_id(o_str_id), .o_last(o_last), .o_beat_cnt(o_beat_cnt), .o_busy(o_busy));

    // Narrow-counter twin on the same stimulus, used to observe counter wrap.
    user_str_rr_arbiter #(.DATA_W(DW), .MAX_BURST(16), .CNT_W(CW2)) dut_w (
        .i_user_clk(clk), .i_rst(rst_n), .i_str_data_valid(vld), .o_str_ack(o2_str_ack),
        .i_str_data(sdata), .o_data_valid(o2_data_valid), .i_ack(ack_in), .o_data(o2_data),
        .o_str_id(o2_str_id), .o_last(o2_last), .o_beat_cnt(o2_beat_cnt), .o_busy(o2_busy));

    int vectors = 0;
    int miscompares = 0;

    int            left [4];
    int            idx  [4];
    logic [65:0]   exp_q [$];
    int            log_id [$];
    int            log_last [$];
    int            log_cyc [$];
    int            cyc = 0;
    logic          held = 1'b0;
    logic [DW-1:0] hold_data;
    logic [1:0]    hold_id;
    logic          hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int n);
        return o_beat_cnt[n*CW +: CW];
    endfunction

    function automatic logic [CW2-1:0] cnt_w(input int n);
        return o2_beat_cnt[n*CW2 +: CW2];
    endfunction

    task automatic drive_inputs();
        for (int n = 0; n < 4; n++) begin
            vld[n] = (left[n] > 0);
            sdata[n*DW +: DW] = {32'(n), 32'(idx[n])};
        end
    endtask

    task automatic clear_model();
        for (int n = 0; n < 4; n++) begin
            left[n] = 0;
            idx[n]  = 0;
        end
        exp_q.delete();
        log_id.delete();
        log_last.delete();
        log_cyc.delete();
        held = 1'b0;
    endtask

    // One clock: drive at negedge, check handshake/output, then advance sources after the edge.
    task automatic tick();
        logic [3:0]  acc;
        logic [65:0] e;
        if (held) begin
            check("hold_data", o_data, hold_data);
            check("hold_id", 64'(o_str_id), 64'(hold_id));
            check("hold_last", 64'(o_last), 64'(hold_last));
        end
        held = 1'b0;
        drive_inputs();
        #1;
        check("ack_onehot", 64'($countones(o_str_ack) <= 1), 64'd1);
        if (o_data_valid && !ack_in) begin
            check("ack_when_stalled", 64'(o_str_ack), 64'd0);
            held      = 1'b1;
            hold_data = o_data;
            hold_id   = o_str_id;
            hold_last = o_last;
        end
        if (o_data_valid && ack_in) begin
            check("out_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", o_data, e[63:0]);
                check("out_id", 64'(o_str_id), 64'(e[65:64]));
            end
            log_id.push_back(int'(o_str_id));
            log_last.push_back(int'(o_last));
            log_cyc.push_back(cyc);
        end
        acc = o_str_ack & vld;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            if (acc[n]) begin
                exp_q.push_back({2'(n), sdata[n*DW +: DW]});
                idx[n]++;
                left[n]--;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        clear_model();
        rst_n  = 1'b0;
        ack_in = 1'b1;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        rst_n  = 1'b0;
        vld    = 4'hF;
        ack_in = 1'b1;
        sdata  = {(4*DW){1'b1}};
        clear_model();

        // Reset held 3 cycles with all valids high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ack", 64'(o_str_ack), 64'd0);
        end
        check("rst_valid", 64'(o_data_valid), 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_id", 64'(o_str_id), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_cnt_lo", o_beat_cnt[63:0], 64'd0);
        check("rst_cnt_hi", o_beat_cnt[127:64], 64'd0);

        // Single stream 2, 40 beats, downstream always ready.
        do_reset();
        left[2] = 40;
        c0 = cyc;
        repeat (50) tick();
        check("s2_beats", 64'(log_id.size()), 64'd40);
        check("s2_first_latency", 64'(log_cyc[0] - c0), 64'd2);
        for (int i = 0; i < 40; i++) begin
            check("s2_id", 64'(log_id[i]), 64'd2);
            check("s2_last", 64'(log_last[i]), 64'((i == 15) || (i == 31)));
        end
        check("s2_back2back", 64'(log_cyc[15] - log_cyc[14]), 64'd1);
        check("s2_gap1", 64'(log_cyc[16] - log_cyc[15]), 64'd2);
        check("s2_gap2", 64'(log_cyc[32] - log_cyc[31]), 64'd2);
        check("s2_cnt", 64'(cnt(2)), 64'd40);
        check("s2_cnt_wrap", 64'(cnt_w(2)), 64'd8);
        check("s2_drained", 64'(exp_q.size()), 64'd0);
        check("s2_busy_idle", 64'(o_busy), 64'd0);

        // All four streams continuously valid: four full rounds.
        do_reset();
        for (int n = 0; n < 4; n++) left[n] = 64;
        repeat (280) tick();
        check("rr_beats", 64'(log_id.size()), 64'd256);
        for (int i = 0; i < 256; i++) begin
            check("rr_id", 64'(log_id[i]), 64'((i / 16) % 4));
            check("rr_last", 64'(log_last[i]), 64'((i % 16) == 15));
        end
        for (int b = 1; b < 16; b++) begin
            check("rr_gap", 64'(log_cyc[b*16] - log_cyc[b*16-1]), 64'd2);
        end
        for (int n = 0; n < 4; n++) begin
            check("rr_cnt", 64'(cnt(n)), 64'd64);
        end

        // Backpressure: downstream ack alternates during a stream-0 burst.
        do_reset();
        left[0] = 10;
        for (int t = 0; t < 40; t++) begin
            ack_in = (t % 2 == 0);
            tick();
        end
        ack_in = 1'b1;
        repeat (4) tick();
        check("bp_beats", 64'(log_id.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check("bp_id", 64'(log_id[i]), 64'd0);
            check("bp_last", 64'(log_last[i]), 64'd0);
        end
        check("bp_cnt", 64'(cnt(0)), 64'd10);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Early release: stream 1 stops after 5 beats, stream 3 waiting.
        do_reset();
        left[1] = 5;
        left[3] = 8;
        repeat (25) tick();
        check("er_beats", 64'(log_id.size()), 64'd13);
        for (int i = 0; i < 13; i++) begin
            check("er_id", 64'(log_id[i]), (i < 5) ? 64'd1 : 64'd3);
            check("er_last", 64'(log_last[i]), 64'd0);
        end
        check("er_switch_gap", 64'(log_cyc[5] - log_cyc[4]), 64'd3);
        check("er_cnt1", 64'(cnt(1)), 64'd5);
        check("er_cnt3", 64'(cnt(3)), 64'd8);
        check("er_cnt0", 64'(cnt(0)), 64'd0);

        // Reset in the middle of a second stream-2 burst.
        do_reset();
        left[2] = 20;
        repeat (20) tick();
        check("mr_pre_beats", 64'(log_id.size()), 64'd17);
        check("mr_pre_valid", 64'(o_data_valid), 64'd1);
        clear_model();
        rst_n = 1'b0;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        check("mr_valid", 64'(o_data_valid), 64'd0);
        check("mr_busy", 64'(o_busy), 64'd0);
        check("mr_ack", 64'(o_str_ack), 64'd0);
        check("mr_cnt2", 64'(cnt(2)), 64'd0);
        rst_n = 1'b1;
        left[0] = 2;
        left[3] = 2;
        repeat (12) tick();
        check("mr_beats", 64'(log_id.size()), 64'd4);
        check("mr_id0", 64'(log_id[0]), 64'd0);
        check("mr_id1", 64'(log_id[1]), 64'd0);
        check("mr_id2", 64'(log_id[2]), 64'd3);
        check("mr_id3", 64'(log_id[3]), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
